// File: rtl/bellman_ford_engine.sv
`default_nettype none
// ============================================================================
//  Module      : bellman_ford_engine
//  Description : Single-source shortest-path engine. It runs Bellman-Ford over
//                an external, synchronously-read edge list and supports signed
//                weights, early exit and negative-cycle detection. Per-vertex
//                distance and predecessor can be read back through a
//                registered query port.
//  Revision    : 1.0 - initial release
// ============================================================================
module bellman_ford_engine #(
    parameter int N_VERT  = 32,
    parameter int N_EDGE  = 64,
    parameter int W_WIDTH = 8,
    parameter int D_WIDTH = 12,
    localparam int VA_W   = $clog2(N_VERT),
    localparam int EA_W   = $clog2(N_EDGE)
) (
    input  logic               clk,
    input  logic               KEY,
    input  logic               start,
    input  logic [VA_W-1:0]    src_vertex,
    input  logic [EA_W:0]      num_edges,
    output logic [EA_W-1:0]    edge_addr,
    input  logic [VA_W-1:0]    edge_u,
    input  logic [VA_W-1:0]    edge_v,
    input  logic [W_WIDTH-1:0] edge_w,
    output logic               busy,
    output logic               done,
    output logic               neg_cycle,
    output logic               err,
    input  logic [VA_W-1:0]    query_vertex,
    output logic [D_WIDTH-1:0] query_dist,
    output logic [VA_W-1:0]    query_pred
);

    // Memory depth covers the full vertex address space so every index is legal.
    localparam int DEPTH = 1 << VA_W;

    localparam logic signed [D_WIDTH-1:0] C_INF      = {1'b0, {(D_WIDTH-1){1'b1}}};
    localparam logic signed [D_WIDTH-1:0] C_DMIN     = {1'b1, {(D_WIDTH-1){1'b0}}};
    localparam logic signed [D_WIDTH:0]   C_INF_X    = {2'b00, {(D_WIDTH-1){1'b1}}};
    localparam logic signed [D_WIDTH:0]   C_DMIN_X   = {2'b11, {(D_WIDTH-1){1'b0}}};
    localparam logic [VA_W-1:0]           C_LAST_VERT = VA_W'(N_VERT - 1);
    localparam logic [VA_W-1:0]           C_LAST_PASS = VA_W'(N_VERT - 2);
    localparam logic [EA_W:0]             C_MAX_EDGES = (EA_W+1)'(N_EDGE);

    typedef enum logic [2:0] {
        S_IDLE        = 3'd0,
        S_INIT        = 3'd1,
        S_FETCH       = 3'd2,
        S_EVAL        = 3'd3,
        S_CHECK_FETCH = 3'd4,
        S_CHECK_EVAL  = 3'd5,
        S_DONE        = 3'd6
    } state_t;

    state_t              state_q, state_d;
    logic [VA_W-1:0]     src_q, src_d;
    logic [EA_W:0]       num_q, num_d;
    logic [EA_W-1:0]     e_q, e_d;
    logic [VA_W-1:0]     vcnt_q, vcnt_d;
    logic [VA_W-1:0]     pass_q, pass_d;
    logic                changed_q, changed_d;
    logic                neg_q, neg_d;
    logic                err_q, err_d;
    logic [D_WIDTH-1:0]  query_dist_q, query_dist_d;
    logic [VA_W-1:0]     query_pred_q, query_pred_d;

    logic signed [D_WIDTH-1:0] dist_mem [0:DEPTH-1];
    logic [VA_W-1:0]           pred_mem [0:DEPTH-1];

    logic                      mem_we;
    logic [VA_W-1:0]           mem_waddr;
    logic signed [D_WIDTH-1:0] mem_wdist;
    logic [VA_W-1:0]           mem_wpred;

    logic signed [D_WIDTH-1:0] du;
    logic signed [D_WIDTH-1:0] dv;
    logic signed [D_WIDTH:0]   sum;
    logic signed [D_WIDTH-1:0] cand;
    logic                      in_range;
    logic                      relax;
    logic                      last_edge;
    logic [EA_W:0]             num_clamped;

    // Relaxation datapath: candidate distance for the edge currently presented.
    always_comb begin
        du       = dist_mem[edge_u];
        dv       = dist_mem[edge_v];
        sum      = {du[D_WIDTH-1], du} + {{(D_WIDTH+1-W_WIDTH){edge_w[W_WIDTH-1]}}, edge_w};
        cand     = sum[D_WIDTH-1:0];
        if (sum < C_DMIN_X) begin
            cand = C_DMIN;
        end
        in_range = (32'(edge_u) < N_VERT) && (32'(edge_v) < N_VERT);
        // An unreachable tail or a sum that reaches INF never improves anything.
        relax    = in_range && (du != C_INF) && (sum < C_INF_X) && (cand < dv);
        last_edge   = ({1'b0, e_q} == (num_q - 1'b1));
        num_clamped = (32'(num_edges) > N_EDGE) ? C_MAX_EDGES : num_edges;
    end

    // Next-state, counter and memory-write control for the sweep sequencer.
    always_comb begin
        state_d   = state_q;
        src_d     = src_q;
        num_d     = num_q;
        e_d       = e_q;
        vcnt_d    = vcnt_q;
        pass_d    = pass_q;
        changed_d = changed_q;
        neg_d     = neg_q;
        err_d     = err_q;
        mem_we    = 1'b0;
        mem_waddr = vcnt_q;
        mem_wdist = C_INF;
        mem_wpred = vcnt_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    src_d     = src_vertex;
                    num_d     = num_clamped;
                    neg_d     = 1'b0;
                    err_d     = 1'b0;
                    e_d       = '0;
                    vcnt_d    = '0;
                    pass_d    = '0;
                    changed_d = 1'b0;
                    if (32'(src_vertex) >= N_VERT) begin
                        err_d   = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        state_d = S_INIT;
                    end
                end
            end

            S_INIT: begin
                mem_we    = 1'b1;
                mem_waddr = vcnt_q;
                mem_wdist = (vcnt_q == src_q) ? '0 : C_INF;
                mem_wpred = vcnt_q;
                vcnt_d    = vcnt_q + 1'b1;
                if (vcnt_q == C_LAST_VERT) begin
                    state_d = (num_q == '0) ? S_DONE : S_FETCH;
                end
            end

            S_FETCH: begin
                state_d = S_EVAL;
            end

            S_EVAL: begin
                if (relax) begin
                    mem_we    = 1'b1;
                    mem_waddr = edge_v;
                    mem_wdist = cand;
                    mem_wpred = edge_u;
                    changed_d = 1'b1;
                end
                if (last_edge) begin
                    if (!(changed_q || relax)) begin
                        state_d = S_DONE;
                    end else if (pass_q == C_LAST_PASS) begin
                        e_d     = '0;
                        state_d = S_CHECK_FETCH;
                    end else begin
                        pass_d    = pass_q + 1'b1;
                        e_d       = '0;
                        changed_d = 1'b0;
                        state_d   = S_FETCH;
                    end
                end else begin
                    e_d     = e_q + 1'b1;
                    state_d = S_FETCH;
                end
            end

            S_CHECK_FETCH: begin
                state_d = S_CHECK_EVAL;
            end

            S_CHECK_EVAL: begin
                // After N_VERT-1 passes any further improvement proves a negative cycle.
                if (relax) begin
                    neg_d   = 1'b1;
                    state_d = S_DONE;
                end else if (last_edge) begin
                    state_d = S_DONE;
                end else begin
                    e_d     = e_q + 1'b1;
                    state_d = S_CHECK_FETCH;
                end
            end

            S_DONE: begin
                if (!start) begin
                    state_d = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Query readback source, registered below for a one-cycle latency.
    always_comb begin
        query_dist_d = dist_mem[query_vertex];
        query_pred_d = pred_mem[query_vertex];
    end

    // Control and status registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge KEY) begin
        if (!KEY) begin
            state_q      <= S_IDLE;
            src_q        <= '0;
            num_q        <= '0;
            e_q          <= '0;
            vcnt_q       <= '0;
            pass_q       <= '0;
            changed_q    <= 1'b0;
            neg_q        <= 1'b0;
            err_q        <= 1'b0;
            query_dist_q <= '0;
            query_pred_q <= '0;
        end else begin
            state_q      <= state_d;
            src_q        <= src_d;
            num_q        <= num_d;
            e_q          <= e_d;
            vcnt_q       <= vcnt_d;
            pass_q       <= pass_d;
            changed_q    <= changed_d;
            neg_q        <= neg_d;
            err_q        <= err_d;
            query_dist_q <= query_dist_d;
            query_pred_q <= query_pred_d;
        end
    end

    // Distance/predecessor storage; contents are not reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            dist_mem[mem_waddr] <= mem_wdist;
            pred_mem[mem_waddr] <= mem_wpred;
        end
    end

    assign edge_addr  = e_q;
    assign busy       = (state_q != S_IDLE) && (state_q != S_DONE);
    assign done       = (state_q == S_DONE);
    assign neg_cycle  = neg_q;
    assign err        = err_q;
    assign query_dist = query_dist_q;
    assign query_pred = query_pred_q;

endmodule
`default_nettype wire
